// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit:
// state encodings, opcode/funct values and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation map; unknown funct falls back to add.
// Ports: funct_i (instr[5:0]) -> alucontrol_o (alu32 op select).
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    unique case (1'b1)
      funct_i == F_ADD: alucontrol_o = ALU_ADD;
      funct_i == F_SUB: alucontrol_o = ALU_SUB;
      funct_i == F_AND: alucontrol_o = ALU_AND;
      funct_i == F_OR:  alucontrol_o = ALU_OR;
      funct_i == F_SLT: alucontrol_o = ALU_SLT;
      default:          alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory handshake and wait timeout.
// Ports: clk/reset, op/funct/zero/mem_ready in; datapath controls,
// illegal_op/mem_timeout pulses and debug state out.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       memread_c, memwrite_c, iord_c, irwrite_c;
  logic       regdst_c, memtoreg_c, regwrite_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] aluctl_c, rtype_ctl;
  logic       pcen_c, illegal_c, timeout_c;
  logic       in_wait, expired;

  alu_decoder u_alu_dec (
    .funct_i      (funct),
    .alucontrol_o (rtype_ctl)
  );

  assign in_wait = (state_q == S_FETCH) ||
                   (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);
  assign expired = in_wait && !mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is zero outside the wait states, so entering one starts
  // at zero; a timeout also clears it for the fresh fetch.
  always_comb begin
    cnt_d = '0;
    if (in_wait && !mem_ready && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_REG;
    aluctl_c   = ALU_AND;
    pcsrc_c    = PC_ALU;
    pcen_c     = 1'b0;
    illegal_c  = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = SRCB_FOUR;
        aluctl_c  = ALU_ADD;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_d   = S_DECODE;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_c = SRCB_IMM4;
        aluctl_c  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        aluctl_c  = ALU_ADD;
        if (op == OP_LW)
          state_d = S_MEMRD;
        else if (op == OP_SW)
          state_d = S_MEMWR;
        else
          state_d = S_FETCH;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (expired) begin
          timeout_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluctl_c  = rtype_ctl;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_c = 1'b1;
        aluctl_c  = ALU_SUB;
        pcsrc_c   = PC_ALUOUT;
        pcen_c    = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        aluctl_c  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc_c = PC_JUMP;
        pcen_c  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output immediately, even mid-instruction,
  // since the state register alone would still show FETCH's memread.
  assign memread     = memread_c  & ~reset;
  assign memwrite    = memwrite_c & ~reset;
  assign iord        = iord_c     & ~reset;
  assign irwrite     = irwrite_c  & ~reset;
  assign regdst      = regdst_c   & ~reset;
  assign memtoreg    = memtoreg_c & ~reset;
  assign regwrite    = regwrite_c & ~reset;
  assign alusrca     = alusrca_c  & ~reset;
  assign alusrcb     = alusrcb_c  & {2{~reset}};
  assign alucontrol  = aluctl_c   & {3{~reset}};
  assign pcsrc       = pcsrc_c    & {2{~reset}};
  assign pcen        = pcen_c     & ~reset;
  assign illegal_op  = illegal_c  & ~reset;
  assign mem_timeout = timeout_c  & ~reset;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller with MEM_WAIT_MAX=4.
// Each cycle: drive inputs, settle 1ns, assert outputs, advance.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       memread, memwrite, iord, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal_op, mem_timeout;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEM_WAIT_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .memread     (memread),
    .memwrite    (memwrite),
    .iord        (iord),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .alucontrol  (alucontrol),
    .pcsrc       (pcsrc),
    .pcen        (pcen),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input logic [5:0] o);
    op = o;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", state, 4'd0);
    chk("fetch_irwrite", {3'b0, irwrite}, 4'd1);
    chk("fetch_pcen", {3'b0, pcen}, 4'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("decode_state", state, 4'd1);
    chk("decode_alusrcb", {2'b0, alusrcb}, 4'd3);
    tick();
  endtask

  logic       lw_mr [11] = '{0,0,0,1,0,0,0,0,1,0,0};
  logic [3:0] lw_st [11] = '{0,0,0,0,1,2,3,3,3,4,0};
  logic       lw_rw [11] = '{0,0,0,0,0,0,0,0,0,1,0};

  initial begin
    #3;
    chk("rst_state", state, 4'd0);
    chk("rst_memread", {3'b0, memread}, 4'd0);
    chk("rst_pcen", {3'b0, pcen}, 4'd0);
    chk("rst_timeout", {3'b0, mem_timeout}, 4'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("first_memread", {3'b0, memread}, 4'd1);

    // lw with 3 FETCH waits and 2 MEMRD waits
    op = 6'b100011;
    for (int i = 0; i < 11; i++) begin
      mem_ready = lw_mr[i];
      #1;
      chk($sformatf("lw_state%0d", i), state, lw_st[i]);
      chk($sformatf("lw_regwrite%0d", i), {3'b0, regwrite},
          {3'b0, lw_rw[i]});
      if (lw_st[i] == 4'd3)
        chk($sformatf("lw_iord%0d", i), {3'b0, iord}, 4'd1);
      tick();
    end

    // beq taken / not taken
    fetch_ok(6'b000100);
    zero = 1'b1;
    #1;
    chk("beq_state", state, 4'd8);
    chk("beq_pcen_z1", {3'b0, pcen}, 4'd1);
    chk("beq_pcsrc", {2'b0, pcsrc}, 4'd1);
    chk("beq_aluctl", {1'b0, alucontrol}, 4'd6);
    zero = 1'b0;
    #1;
    chk("beq_pcen_z0", {3'b0, pcen}, 4'd0);
    tick();
    #1;
    chk("beq_back", state, 4'd0);

    // R-type slt
    funct = 6'b101010;
    fetch_ok(6'b000000);
    #1;
    chk("rt_state", state, 4'd6);
    chk("rt_aluctl", {1'b0, alucontrol}, 4'd7);
    chk("rt_alusrca", {3'b0, alusrca}, 4'd1);
    funct = 6'b100010;
    #1;
    chk("rt_sub", {1'b0, alucontrol}, 4'd6);
    funct = 6'b111000;
    #1;
    chk("rt_dflt", {1'b0, alucontrol}, 4'd2);
    tick();
    #1;
    chk("rtwb_state", state, 4'd7);
    chk("rtwb_regdst", {3'b0, regdst}, 4'd1);
    chk("rtwb_regwrite", {3'b0, regwrite}, 4'd1);
    tick();

    // addi
    fetch_ok(6'b001000);
    #1;
    chk("addi_state", state, 4'd9);
    chk("addi_srcb", {2'b0, alusrcb}, 4'd2);
    tick();
    #1;
    chk("addiwb_state", state, 4'd10);
    chk("addiwb_rw", {3'b0, regwrite}, 4'd1);
    chk("addiwb_regdst", {3'b0, regdst}, 4'd0);
    tick();

    // illegal opcode
    op = 6'b111111;
    mem_ready = 1'b1;
    #1;
    chk("ill_fetch", state, 4'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ill_state", state, 4'd1);
    chk("ill_pulse", {3'b0, illegal_op}, 4'd1);
    tick();
    #1;
    chk("ill_back", state, 4'd0);
    chk("ill_clear", {3'b0, illegal_op}, 4'd0);
    chk("ill_norw", {3'b0, regwrite}, 4'd0);

    // jump
    fetch_ok(6'b000010);
    #1;
    chk("j_state", state, 4'd11);
    chk("j_pcsrc", {2'b0, pcsrc}, 4'd2);
    chk("j_pcen", {3'b0, pcen}, 4'd1);
    tick();

    // sw with memory never ready: timeout on 4th wait cycle
    fetch_ok(6'b101011);
    #1;
    chk("sw_adr", state, 4'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("sw_state%0d", i), state, 4'd5);
      chk($sformatf("sw_memwrite%0d", i), {3'b0, memwrite}, 4'd1);
      chk($sformatf("sw_timeout%0d", i), {3'b0, mem_timeout},
          (i == 3) ? 4'd1 : 4'd0);
      tick();
    end
    #1;
    chk("sw_back", state, 4'd0);
    chk("sw_to_clear", {3'b0, mem_timeout}, 4'd0);
    chk("sw_no_ir", {3'b0, irwrite}, 4'd0);

    // reset in MEMWB
    fetch_ok(6'b100011);
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("wb_state", state, 4'd4);
    chk("wb_rw", {3'b0, regwrite}, 4'd1);
    reset = 1'b1;
    #1;
    chk("rstwb_state", state, 4'd0);
    chk("rstwb_rw", {3'b0, regwrite}, 4'd0);
    chk("rstwb_memread", {3'b0, memread}, 4'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_memread", {3'b0, memread}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL declare parameter MEM_WAIT_MAX, default 255, meaning the maximum number of mem_ready wait cycles before mem_timeout.
REQ-002 SHALL declare ports, one per line, in this order:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  alu32 zero flag
- mem_ready  in  1  memory completion strobe for the current request
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- irwrite  out  1  instruction register enable
- regdst  out  1  register write address select: 1 = rd, 0 = rt
- memtoreg  out  1  register write data select: 1 = memory data
- regwrite  out  1  regfile we3
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = signext, 11 = signext shifted left by 2
- alucontrol  out  3  alu32 operation select
- pcsrc  out  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump target
- pcen  out  1  PC register enable
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when a memory wait is abandoned
- state  out  4  current state, for debug

Function
REQ-003 SHALL implement these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; encodings 12-15 SHALL go to FETCH on the next clock.
REQ-004 SHALL use these transitions:
- FETCH -> DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH with illegal_op=1 for that cycle.
- MEMADR -> MEMRD for op=100011, MEMWR for op=101011.
- MEMRD -> MEMWB on mem_ready; otherwise stay.
- MEMWR -> FETCH on mem_ready; otherwise stay.
- MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
- RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
REQ-005 SHALL drive outputs per state; any output not listed SHALL be 0:
- FETCH: memread=1, alusrcb=01, alucontrol=010; irwrite=mem_ready; pcen=mem_ready.
- DECODE: alusrcb=11, alucontrol=010.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucontrol=010.
- MEMRD: memread=1, iord=1.
- MEMWR: memwrite=1, iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- RTYPEEX: alusrca=1, alucontrol=alu_decoder(funct).
- RTYPEWB: regwrite=1, regdst=1.
- ADDIWB: regwrite=1.
- BEQEX: alusrca=1, alucontrol=110, pcsrc=01, pcen=zero.
- JEX: pcsrc=10, pcen=1.
REQ-006 SHALL map funct to alucontrol as: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct SHALL give 010.
REQ-007 SHALL hold memread/memwrite and iord stable from request assertion until the cycle mem_ready=1 is sampled; mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-008 SHALL count wait cycles in a counter reset on entry to FETCH/MEMRD/MEMWR; at MEM_WAIT_MAX cycles without mem_ready it SHALL pulse mem_timeout for 1 cycle and go to FETCH, with no irwrite/regwrite/pcen asserted.
REQ-009 SHALL give the following latencies with mem_ready=1 on the first cycle: R-type 4, addi 4, beq 3, j 3, sw 4, lw 5 cycles.

Reset
REQ-010 SHALL on reset=1 asynchronously set state=FETCH and clear the wait counter, illegal_op and mem_timeout.
REQ-011 SHALL force memread, memwrite, irwrite, regwrite and pcen to 0 while reset=1, including a reset asserted mid-instruction.
REQ-012 SHALL issue its first memread in the first cycle after reset deasserts.

Structure
REQ-013 SHALL place the state encodings, opcode and funct constants, and alucontrol codes in the shared package mips_ctrl_pkg.
REQ-014 SHALL place the funct-to-alucontrol map in one sub-module, alu_decoder.

Verification
REQ-015 SHALL cover: lw (op=100011) with mem_ready delayed 3 cycles in FETCH and 2 cycles in MEMRD -> states 0,0,0,0,1,2,3,3,3,4,0 and regwrite=1 only in state 4.
REQ-016 SHALL cover: beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0.
REQ-017 SHALL cover: R-type funct=101010 -> alucontrol=111 in RTYPEEX, then regdst=1 and regwrite=1 in the next cycle.
REQ-018 SHALL cover: op=111111 -> illegal_op pulse of 1 cycle in DECODE, then FETCH with no regwrite.
REQ-019 SHALL cover: MEM_WAIT_MAX=4 with mem_ready held 0 in MEMWR -> mem_timeout=1 in the 4th wait cycle, then state=0.
REQ-020 SHALL cover: reset asserted in MEMWB -> state=0 immediately and regwrite=0 in the same cycle.
